// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port 8-bit memory among requesters: instruction fetch (IF),
// data access (D) and, when MEM_ARB_DBG_EN is defined, a debug port (DBG).
// Priority is DBG > D > IF. After STARVE_LIMIT data grants in a row with IF
// waiting, IF takes one slot. Grants are combinational so the pipeline can
// stall in the same cycle. Read data comes back one cycle after the grant and
// is routed to the requester recorded in the read tag.
// MEM_ARB_DBG_EN: define to add the debug requester ports and logic.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       if_req,
  input  logic [7:0] if_addr,
  output logic       if_gnt,
  output logic       if_rvalid,
  output logic [7:0] if_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic [7:0] d_rdata,
`ifdef MEM_ARB_DBG_EN
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [7:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
`endif
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D, TAG_DBG} tag_t;

  tag_t             tag_q;
  logic [CNT_W-1:0] streak_q;
  logic             starve;
  logic             gnt_if;
  logic             gnt_d;
  logic             gnt_dbg;

  // Grant selection; everything is held off while rstn is low.
  always_comb begin
    starve = (STARVE_LIMIT != 0) && (streak_q == LIMIT) && if_req;
`ifdef MEM_ARB_DBG_EN
    gnt_dbg = rstn & dbg_req;
`else
    gnt_dbg = 1'b0;
`endif
    gnt_d  = rstn & d_req & ~starve & ~gnt_dbg;
    gnt_if = rstn & if_req & ~gnt_d & ~gnt_dbg;
  end

  assign if_gnt = gnt_if;
  assign d_gnt  = gnt_d;
`ifdef MEM_ARB_DBG_EN
  assign dbg_gnt = gnt_dbg;
`endif

  // Memory port mux driven by the winner; idle port drives zeros.
  always_comb begin
    mem_en    = gnt_if | gnt_d | gnt_dbg;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    if (gnt_dbg) begin
`ifdef MEM_ARB_DBG_EN
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
`endif
    end else if (gnt_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (gnt_if) begin
      mem_addr = if_addr;
    end
  end

  // Streak of data grants that passed over a waiting fetch; debug grants leave it alone.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      streak_q <= '0;
    end else if (gnt_dbg) begin
      streak_q <= streak_q;
    end else if (gnt_if || !if_req) begin
      streak_q <= '0;
    end else if (gnt_d && (streak_q != LIMIT)) begin
      streak_q <= streak_q + CNT_W'(1);
    end
  end

  // Read tag: remembers who owns the data coming back next cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_q <= TAG_NONE;
    end else if (gnt_dbg) begin
`ifdef MEM_ARB_DBG_EN
      tag_q <= dbg_we ? TAG_NONE : TAG_DBG;
`else
      tag_q <= TAG_NONE;
`endif
    end else if (gnt_d) begin
      tag_q <= d_we ? TAG_NONE : TAG_D;
    end else if (gnt_if) begin
      tag_q <= TAG_IF;
    end else begin
      tag_q <= TAG_NONE;
    end
  end

  // Read return routing; the rstn gate keeps outputs quiet while in reset.
  always_comb begin
    if_rvalid = rstn && (tag_q == TAG_IF);
    d_rvalid  = rstn && (tag_q == TAG_D);
    if_rdata  = if_rvalid ? mem_rdata : 8'h00;
    d_rdata   = d_rvalid  ? mem_rdata : 8'h00;
`ifdef MEM_ARB_DBG_EN
    dbg_rvalid = rstn && (tag_q == TAG_DBG);
    dbg_rdata  = dbg_rvalid ? mem_rdata : 8'h00;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
// Define MEM_ARB_DBG_EN to also exercise the debug requester.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int W_NONE = 0;
  localparam int W_IF   = 1;
  localparam int W_D    = 2;
  localparam int W_DBG  = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_gnt, if_rvalid;
  logic [7:0] if_rdata;
  logic       d_req, d_we;
  logic [7:0] d_addr, d_wdata;
  logic       d_gnt, d_rvalid;
  logic [7:0] d_rdata;
`ifdef MEM_ARB_DBG_EN
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
`endif
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_streak;
  int         m_tag;
  logic [7:0] m_rdata;
  logic [7:0] gmem [256];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
`ifdef MEM_ARB_DBG_EN
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
`endif
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous write-first RAM driven by the DUT's memory port.
  logic [7:0] ram [256];
  logic       ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Who should own the port this cycle, from the arbitration rules.
  function automatic int model_winner();
    if (!rstn) return W_NONE;
`ifdef MEM_ARB_DBG_EN
    if (dbg_req) return W_DBG;
`endif
    if (d_req && !(STARVE_LIMIT > 0 && m_streak >= STARVE_LIMIT && if_req)) return W_D;
    if (if_req) return W_IF;
    return W_NONE;
  endfunction

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r < 6) return 8'(8'h30 + r);
    return (r == 6) ? 8'hFF : 8'h00;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Check every DUT output for the current cycle, then advance the model past the next edge.
  task automatic cycle_check(output int w);
    logic [7:0] e_addr, e_wdata;
    logic       e_we;
    logic       v;
    #1;
    w = model_winner();
    e_addr = 8'h00; e_wdata = 8'h00; e_we = 1'b0;
    case (w)
      W_IF: e_addr = if_addr;
      W_D: begin e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; end
`ifdef MEM_ARB_DBG_EN
      W_DBG: begin e_addr = dbg_addr; e_we = dbg_we; e_wdata = dbg_wdata; end
`endif
      default: ;
    endcase
    check_val("if_gnt",    32'(if_gnt),    32'(w == W_IF));
    check_val("d_gnt",     32'(d_gnt),     32'(w == W_D));
    check_val("mem_en",    32'(mem_en),    32'(w != W_NONE));
    check_val("mem_we",    32'(mem_we),    32'(e_we));
    check_val("mem_addr",  32'(mem_addr),  32'(e_addr));
    check_val("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    v = rstn && (m_tag == W_IF);
    check_val("if_rvalid", 32'(if_rvalid), 32'(v));
    check_val("if_rdata",  32'(if_rdata),  v ? 32'(m_rdata) : 32'd0);
    v = rstn && (m_tag == W_D);
    check_val("d_rvalid",  32'(d_rvalid),  32'(v));
    check_val("d_rdata",   32'(d_rdata),   v ? 32'(m_rdata) : 32'd0);
`ifdef MEM_ARB_DBG_EN
    check_val("dbg_gnt",   32'(dbg_gnt),   32'(w == W_DBG));
    v = rstn && (m_tag == W_DBG);
    check_val("dbg_rvalid", 32'(dbg_rvalid), 32'(v));
    check_val("dbg_rdata",  32'(dbg_rdata),  v ? 32'(m_rdata) : 32'd0);
`endif
    if (!rstn) begin
      m_streak = 0;
      m_tag    = W_NONE;
    end else begin
      case (w)
        W_IF:   m_streak = 0;
        W_D:    m_streak = if_req ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : m_streak) : 0;
        W_NONE: if (!if_req) m_streak = 0;
        default: ;
      endcase
      m_tag = W_NONE;
      if (w != W_NONE && !e_we) begin
        m_tag   = w;
        m_rdata = gmem[e_addr];
      end
      if (w != W_NONE && e_we) gmem[e_addr] = e_wdata;
    end
  endtask

  task automatic set_idle();
    if_req = 1'b0; if_addr = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
`ifdef MEM_ARB_DBG_EN
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
`endif
  endtask

  task automatic set_d(input logic we, input logic [7:0] a, input logic [7:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  initial begin : main
    int w;
    logic [9:0] pat;
    logic got_if, got_d, got_dbg;
    for (int i = 0; i < 256; i++) gmem[i] = 8'(i) ^ 8'h5A;
    m_streak = 0; m_tag = W_NONE; m_rdata = 8'h00;
    rstn = 1'b0;
    set_idle();

    // reset, including requests that must be ignored
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (i == 1) begin if_req = 1'b1; if_addr = 8'h44; set_d(1'b1, 8'h45, 8'h99); end
      cycle_check(w);
      check_val("rst_mem_en", 32'(mem_en), 32'd0);
    end
    next_cycle(); rstn = 1'b1; set_idle(); cycle_check(w);

    // fetch only: preload 0x10 = C5 via a data write, then fetch it
    next_cycle(); set_d(1'b1, 8'h10, 8'hC5); cycle_check(w);
    next_cycle(); set_idle(); if_req = 1'b1; if_addr = 8'h10; cycle_check(w);
    check_val("t1_if_gnt", 32'(if_gnt), 32'd1);
    next_cycle(); set_idle(); cycle_check(w);
    check_val("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    check_val("t1_if_rdata", 32'(if_rdata), 32'hC5);

    // contention: data read beats fetch, fetch goes once data drops
    next_cycle(); set_d(1'b1, 8'h30, 8'h0A); cycle_check(w);
    next_cycle(); set_d(1'b0, 8'h30, 8'h00); if_req = 1'b1; if_addr = 8'h12; cycle_check(w);
    check_val("t2_d_gnt", 32'(d_gnt), 32'd1);
    check_val("t2_if_gnt", 32'(if_gnt), 32'd0);
    next_cycle(); d_req = 1'b0; cycle_check(w);
    check_val("t2_d_rdata", 32'(d_rdata), 32'h0A);
    check_val("t2_if_gnt_after", 32'(if_gnt), 32'd1);
    next_cycle(); set_idle(); cycle_check(w);

    // starvation: D,D,D,D,IF repeating
    pat = 10'b0111101111;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); set_d(1'b0, 8'h20, 8'h00); if_req = 1'b1; if_addr = 8'h21;
      cycle_check(w);
      check_val("t3_d_gnt", 32'(d_gnt), 32'(pat[i]));
    end
    next_cycle(); set_idle(); cycle_check(w);

    // write then immediate readback
    next_cycle(); set_d(1'b1, 8'h31, 8'h14); cycle_check(w);
    check_val("t4_mem_we", 32'(mem_we), 32'd1);
    next_cycle(); set_d(1'b0, 8'h31, 8'h00); cycle_check(w);
    check_val("t4_no_rvalid", 32'(d_rvalid), 32'd0);
    next_cycle(); set_idle(); cycle_check(w);
    check_val("t4_d_rvalid", 32'(d_rvalid), 32'd1);
    check_val("t4_d_rdata", 32'(d_rdata), 32'h14);

    // reset cuts off a read in flight
    next_cycle(); set_d(1'b0, 8'h30, 8'h00); cycle_check(w);
    next_cycle(); set_idle(); rstn = 1'b0; cycle_check(w);
    check_val("t5_rvalid_rst", 32'(d_rvalid), 32'd0);
    next_cycle(); rstn = 1'b1; cycle_check(w);
    check_val("t5_rvalid_after", 32'(d_rvalid), 32'd0);

`ifdef MEM_ARB_DBG_EN
    // debug write takes the port without touching the streak
    for (int i = 0; i < 2; i++) begin
      next_cycle(); set_d(1'b0, 8'h22, 8'h00); if_req = 1'b1; if_addr = 8'h23; cycle_check(w);
    end
    next_cycle(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h00; dbg_wdata = 8'h10; cycle_check(w);
    check_val("t6_dbg_gnt", 32'(dbg_gnt), 32'd1);
    check_val("t6_d_gnt", 32'(d_gnt), 32'd0);
    check_val("t6_if_gnt", 32'(if_gnt), 32'd0);
    pat = 10'b0000000011;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); dbg_req = 1'b0; cycle_check(w);
      check_val("t6_streak_d_gnt", 32'(d_gnt), 32'(pat[i]));
    end
    next_cycle(); set_idle(); cycle_check(w);
`endif

    // randomized traffic; requesters hold until granted
    got_if = 1'b0; got_d = 1'b0; got_dbg = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (got_if) if_req = 1'b0;
      if (got_d) d_req = 1'b0;
      rstn = ($urandom_range(0, 49) != 0);
      if (!if_req && $urandom_range(0, 2) != 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 1) != 0)
        set_d(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
`ifdef MEM_ARB_DBG_EN
      if (got_dbg) dbg_req = 1'b0;
      if (!dbg_req && $urandom_range(0, 7) == 0) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = 8'($urandom);
      end
`endif
      cycle_check(w);
      got_if  = (w == W_IF);
      got_d   = (w == W_D);
      got_dbg = (w == W_DBG);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
